// File: rtl/pu_fram_mc_pkg.sv
// ----------------------------------------------------------------------------
// pu_fram_mc_pkg
//   Shared types and helpers for the multi-channel frame RAM processing unit.
//
//   Contents:
//     state_e     - sweep/run state of the controller
//     word_width  - width of one stored {attr, data} word
//     addr_ok     - range check for addresses when RAM_SIZE is not a power of two
// ----------------------------------------------------------------------------
package pu_fram_mc_pkg;

    typedef enum logic {
        CLEAR = 1'b0,   // post-reset sweep writing zeros into every word
        RUN   = 1'b1    // normal operation, left only through reset
    } state_e;

    // Width of one bank word; attribute bits sit above the data bits.
    function automatic int word_width(input int data_width, input int attr_width);
        return data_width + attr_width;
    endfunction

    // Addresses are ADDR_WIDTH bits wide, so for a non-power-of-two RAM_SIZE
    // some encodable addresses do not exist and must be ignored.
    function automatic logic addr_ok(input logic [31:0] addr, input logic [31:0] size);
        return addr < size;
    endfunction

endpackage

// File: rtl/pu_fram_mc_if.sv
// ----------------------------------------------------------------------------
// pu_fram_mc_if
//   Data-bus bundle between the control microcode and pu_fram_mc.
//
//   Signals:
//     signal_addr / signal_wr / data_in / attr_in - write channel
//     signal_oe    [N_RD]                          - per-channel read enable
//     signal_raddr [N_RD*ADDR_WIDTH]               - packed read addresses
//     data_out     [N_RD*DATA_WIDTH]               - packed read data
//     attr_out     [N_RD*ATTR_WIDTH]               - packed read attributes
//     busy                                         - clear sweep in progress
//   Channel i occupies slice [i*W +: W] of every packed vector.
//
//   Modports: master (microcode side), slave (memory side).
// ----------------------------------------------------------------------------
interface pu_fram_mc_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ATTR_WIDTH = 4,
    parameter int N_RD       = 2
);

    logic [ADDR_WIDTH-1:0]      signal_addr;
    logic                       signal_wr;
    logic [DATA_WIDTH-1:0]      data_in;
    logic [ATTR_WIDTH-1:0]      attr_in;
    logic [N_RD-1:0]            signal_oe;
    logic [N_RD*ADDR_WIDTH-1:0] signal_raddr;
    logic [N_RD*DATA_WIDTH-1:0] data_out;
    logic [N_RD*ATTR_WIDTH-1:0] attr_out;
    logic                       busy;

    modport master (
        output signal_addr, signal_wr, data_in, attr_in, signal_oe, signal_raddr,
        input  data_out, attr_out, busy
    );

    modport slave (
        input  signal_addr, signal_wr, data_in, attr_in, signal_oe, signal_raddr,
        output data_out, attr_out, busy
    );

endinterface

// File: rtl/pu_fram_rd_port.sv
// ----------------------------------------------------------------------------
// pu_fram_rd_port
//   One registered read channel of pu_fram_mc (latency 1).
//
//   Ports:
//     clk, rst_n   - clock, synchronous active-low reset
//     busy         - clear sweep running; output forced to zero
//     oe, raddr    - read enable and address for this channel
//     bank_word    - bank[raddr] as it stands before this edge's commit
//     stage_*      - staged write (only with PU_FRAM_MC_FORWARD_EN)
//     data, attr   - registered read result
//
//   Build option: PU_FRAM_MC_FORWARD_EN adds a bypass from the staged write
//   so a write is visible one cycle earlier.
// ----------------------------------------------------------------------------
module pu_fram_rd_port
    import pu_fram_mc_pkg::*;
#(
    parameter int  RAM_SIZE   = 16,
    parameter int  DATA_WIDTH = 32,
    parameter int  ATTR_WIDTH = 4,
    parameter int  ADDR_WIDTH = 4,
    localparam int WORD_WIDTH = word_width(DATA_WIDTH, ATTR_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  busy,
    input  logic                  oe,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic [WORD_WIDTH-1:0] bank_word,
`ifdef PU_FRAM_MC_FORWARD_EN
    input  logic                  stage_wr,
    input  logic [ADDR_WIDTH-1:0] stage_addr,
    input  logic [DATA_WIDTH-1:0] stage_data,
    input  logic [ATTR_WIDTH-1:0] stage_attr,
`endif
    output logic [DATA_WIDTH-1:0] data,
    output logic [ATTR_WIDTH-1:0] attr
);

    logic [WORD_WIDTH-1:0] word_d;

    always_comb begin
        word_d = '0;
        if (!busy && oe && addr_ok(32'(raddr), 32'(RAM_SIZE))) begin
            word_d = bank_word;
`ifdef PU_FRAM_MC_FORWARD_EN
            // The staged write commits on this same edge; hand its value out
            // directly instead of the stale bank word.
            if (stage_wr && (stage_addr == raddr)) begin
                word_d = {stage_attr, stage_data};
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data <= '0;
            attr <= '0;
        end else begin
            {attr, data} <= word_d;
        end
    end

endmodule

// File: rtl/pu_fram_mc.sv
// ----------------------------------------------------------------------------
// pu_fram_mc
//   Frame RAM processing unit: one {attr, data} bank, one two-stage registered
//   write channel and N_RD independent registered read channels. After every
//   reset the whole bank is swept to zero while busy is high.
//
//   Ports:
//     clk    - clock, all logic on the rising edge
//     rst_n  - synchronous active-low reset
//     bus    - pu_fram_mc_if.slave: write channel, read channels, busy
//
//   Parameters: RAM_SIZE (>= 2, any value), DATA_WIDTH, ATTR_WIDTH,
//   N_RD (1..8); ADDR_WIDTH is derived.
//
//   Build option: PU_FRAM_MC_FORWARD_EN enables write-to-read forwarding of
//   the staged write inside each read channel.
// ----------------------------------------------------------------------------
module pu_fram_mc
    import pu_fram_mc_pkg::*;
#(
    parameter int  RAM_SIZE   = 16,
    parameter int  DATA_WIDTH = 32,
    parameter int  ATTR_WIDTH = 4,
    parameter int  N_RD       = 2,
    localparam int ADDR_WIDTH = $clog2(RAM_SIZE)
) (
    input  logic        clk,
    input  logic        rst_n,
    pu_fram_mc_if.slave bus
);

    localparam int WORD_WIDTH = word_width(DATA_WIDTH, ATTR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_SIZE - 1);

    // ------------------------------------------------------------------
    // Clear-sweep controller
    // ------------------------------------------------------------------
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
    logic                  busy_q, busy_d;
    logic                  clr_we;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        busy_d    = busy_q;
        clr_we    = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we    = 1'b1;
                clr_ptr_d = clr_ptr_q + ADDR_WIDTH'(1);
                if (clr_ptr_q == LAST_ADDR) begin
                    state_d   = RUN;
                    busy_d    = 1'b0;
                    clr_ptr_d = '0;
                end
            end
            RUN: begin
                // Stays here until the next reset.
            end
        endcase
    end

    assign bus.busy = busy_q;

    // ------------------------------------------------------------------
    // Write staging: sample on edge t, commit on edge t+1
    // ------------------------------------------------------------------
    logic                  stage_wr;
    logic [ADDR_WIDTH-1:0] stage_addr;
    logic [DATA_WIDTH-1:0] stage_data;
    logic [ATTR_WIDTH-1:0] stage_attr;
    logic                  commit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_wr <= 1'b0;
        end else begin
            // Writes requested during the sweep are discarded here.
            stage_wr <= (state_q == RUN) && bus.signal_wr;
        end
    end

    // Payload registers only matter when stage_wr is set.
    always_ff @(posedge clk) begin
        stage_addr <= bus.signal_addr;
        stage_data <= bus.data_in;
        stage_attr <= bus.attr_in;
    end

    assign commit = (state_q == RUN) && stage_wr &&
                    addr_ok(32'(stage_addr), 32'(RAM_SIZE));

    // ------------------------------------------------------------------
    // Bank
    // ------------------------------------------------------------------
    logic [WORD_WIDTH-1:0] bank [RAM_SIZE];

    // NOTE: the bank has no reset branch; a reset edge leaves contents alone
    // and zeroing is done by the sweep, one word per cycle, so the array can
    // map onto plain RAM.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (clr_we) begin
                bank[clr_ptr_q] <= '0;
            end else if (commit) begin
                bank[stage_addr] <= {stage_attr, stage_data};
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channels
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] rd_data [N_RD];
    logic [ATTR_WIDTH-1:0] rd_attr [N_RD];

    for (genvar i = 0; i < N_RD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] raddr;
        logic [WORD_WIDTH-1:0] bank_word;

        assign raddr = bus.signal_raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        // Out-of-range addresses index past the bank; the channel discards
        // that word through its own range check.
        assign bank_word = bank[raddr];

        pu_fram_rd_port #(
            .RAM_SIZE   (RAM_SIZE),
            .DATA_WIDTH (DATA_WIDTH),
            .ATTR_WIDTH (ATTR_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_rd_port (
            .clk        (clk),
            .rst_n      (rst_n),
            .busy       (busy_q),
            .oe         (bus.signal_oe[i]),
            .raddr      (raddr),
            .bank_word  (bank_word),
`ifdef PU_FRAM_MC_FORWARD_EN
            .stage_wr   (stage_wr),
            .stage_addr (stage_addr),
            .stage_data (stage_data),
            .stage_attr (stage_attr),
`endif
            .data       (rd_data[i]),
            .attr       (rd_attr[i])
        );
    end

    always_comb begin
        bus.data_out = '0;
        bus.attr_out = '0;
        for (int i = 0; i < N_RD; i++) begin
            bus.data_out[i*DATA_WIDTH +: DATA_WIDTH] = rd_data[i];
            bus.attr_out[i*ATTR_WIDTH +: ATTR_WIDTH] = rd_attr[i];
        end
    end

endmodule
